// File: rtl/issue_queue_int_pkg.sv
// Shared types and default sizes for the integer issue queue.
package issue_queue_int_pkg;

    localparam int IQ_DEPTH_DEFAULT       = 16;
    localparam int DISPATCH_WIDTH_DEFAULT = 4;
    localparam int WAKEUP_WIDTH_DEFAULT   = 4;
    localparam int PRF_INDEX_SIZE         = 6;
    localparam int ISSUE_WIDTH_INT        = 2;

    // Only valid, rs1/rs2/rd pregs and rd_valid are interpreted; the rest rides along.
    typedef struct packed {
        logic                      valid;
        logic [31:0]               pc;
        logic [7:0]                opcode;
        logic [PRF_INDEX_SIZE-1:0] rs1_preg;
        logic [PRF_INDEX_SIZE-1:0] rs2_preg;
        logic [PRF_INDEX_SIZE-1:0] rd_preg;
        logic                      rd_valid;
        logic [31:0]               imm;
    } micro_op_t;

    typedef struct packed {
        micro_op_t uop;
        logic      rs1_rdy;
        logic      rs2_rdy;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_int_select.sv
// Age-ordered priority picker: grant k is one-hot on the k-th ready entry from index 0.
module iq_select
    import issue_queue_int_pkg::*;
#(
    parameter int N = IQ_DEPTH_DEFAULT,
    parameter int W = ISSUE_WIDTH_INT
) (
    input  logic [N-1:0]        i_ready,
    output logic [W-1:0][N-1:0] o_grant
);

    always_comb begin
        logic [N-1:0] taken;
        logic         found;
        o_grant = '0;
        taken   = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < W; k++) begin
            found = 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && i_ready[i] && !taken[i]) begin
                    o_grant[k][i] = 1'b1;
                    taken[i]      = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue_int.sv
// Compacting integer issue queue with wakeup tracking and oldest-ready select.
// Optional macro IQ_SELF_WAKEUP_EN: issued uops broadcast rd_preg as an internal wakeup.
module issue_queue_int
    import issue_queue_int_pkg::*;
#(
    parameter int IQ_DEPTH       = IQ_DEPTH_DEFAULT,
    parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEFAULT,
    parameter int WAKEUP_WIDTH   = WAKEUP_WIDTH_DEFAULT
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         clear,
    input  logic                                         stall,
    input  micro_op_t [DISPATCH_WIDTH-1:0]               dp_uop,
    input  logic [DISPATCH_WIDTH-1:0]                    dp_rs1_ready,
    input  logic [DISPATCH_WIDTH-1:0]                    dp_rs2_ready,
    input  logic [WAKEUP_WIDTH-1:0]                      wakeup_valid,
    input  logic [WAKEUP_WIDTH-1:0][PRF_INDEX_SIZE-1:0]  wakeup_preg,
    output micro_op_t [ISSUE_WIDTH_INT-1:0]              is_uop_int,
    output logic                                         iq_full,
    output logic [$clog2(IQ_DEPTH):0]                    iq_free_count
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam int IW = $clog2(IQ_DEPTH);
`ifdef IQ_SELF_WAKEUP_EN
    localparam int NWK = WAKEUP_WIDTH + ISSUE_WIDTH_INT;
`else
    localparam int NWK = WAKEUP_WIDTH;
`endif

    iq_entry_t [IQ_DEPTH-1:0]               r_entries;
    logic [CW-1:0]                          r_free_count;
    logic                                   r_full;

    logic [IQ_DEPTH-1:0]                    w_ready;
    logic [ISSUE_WIDTH_INT-1:0][IQ_DEPTH-1:0] w_grant;
    logic [IQ_DEPTH-1:0]                    w_issued;
    logic [NWK-1:0]                         w_wk_valid;
    logic [NWK-1:0][PRF_INDEX_SIZE-1:0]     w_wk_preg;
    iq_entry_t [IQ_DEPTH-1:0]               w_next;
    logic [CW-1:0]                          w_next_count;
    logic [CW-1:0]                          w_next_free;

    function automatic logic f_woken(
        input logic [PRF_INDEX_SIZE-1:0]           preg,
        input logic [NWK-1:0]                      v,
        input logic [NWK-1:0][PRF_INDEX_SIZE-1:0]  p
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < NWK; k++) begin
            if (v[k] && p[k] == preg) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            w_ready[i] = !stall && r_entries[i].uop.valid &&
                         r_entries[i].rs1_rdy && r_entries[i].rs2_rdy;
        end
    end

    iq_select #(
        .N (IQ_DEPTH),
        .W (ISSUE_WIDTH_INT)
    ) u_select (
        .i_ready (w_ready),
        .o_grant (w_grant)
    );

    always_comb begin
        is_uop_int = '0;
        w_issued   = '0;
        for (int unsigned k = 0; k < ISSUE_WIDTH_INT; k++) begin
            for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
                if (w_grant[k][i]) begin
                    is_uop_int[k] = r_entries[i].uop;
                    w_issued[i]   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_wk_valid = '0;
        w_wk_preg  = '0;
        for (int unsigned p = 0; p < WAKEUP_WIDTH; p++) begin
            w_wk_valid[p] = wakeup_valid[p];
            w_wk_preg[p]  = wakeup_preg[p];
        end
`ifdef IQ_SELF_WAKEUP_EN
        // is_uop_int is already zero under stall, so no broadcast leaks out of a stalled cycle.
        for (int unsigned k = 0; k < ISSUE_WIDTH_INT; k++) begin
            w_wk_valid[WAKEUP_WIDTH+k] = is_uop_int[k].valid && is_uop_int[k].rd_valid;
            w_wk_preg[WAKEUP_WIDTH+k]  = is_uop_int[k].rd_preg;
        end
`endif
    end

    // Survivors are packed from index 0 in age order, then dispatch slots are appended.
    // Room is limited by pre-issue occupancy, so issued slots are reusable only next cycle.
    always_comb begin
        iq_entry_t     e;
        logic [CW-1:0] pos;
        logic [CW-1:0] room;
        e      = '0;
        pos    = '0;
        room   = r_free_count;
        w_next = '0;
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            if (r_entries[i].uop.valid && !w_issued[i]) begin
                e         = r_entries[i];
                e.rs1_rdy = e.rs1_rdy | f_woken(e.uop.rs1_preg, w_wk_valid, w_wk_preg);
                e.rs2_rdy = e.rs2_rdy | f_woken(e.uop.rs2_preg, w_wk_valid, w_wk_preg);
                w_next[pos[IW-1:0]] = e;
                pos       = pos + CW'(1);
            end
        end
        for (int unsigned d = 0; d < DISPATCH_WIDTH; d++) begin
            if (dp_uop[d].valid && room != '0) begin
                e         = '0;
                e.uop     = dp_uop[d];
                e.rs1_rdy = dp_rs1_ready[d] || (dp_uop[d].rs1_preg == '0) ||
                            f_woken(dp_uop[d].rs1_preg, w_wk_valid, w_wk_preg);
                e.rs2_rdy = dp_rs2_ready[d] || (dp_uop[d].rs2_preg == '0) ||
                            f_woken(dp_uop[d].rs2_preg, w_wk_valid, w_wk_preg);
                w_next[pos[IW-1:0]] = e;
                pos       = pos + CW'(1);
                room      = room - CW'(1);
            end
        end
        w_next_count = pos;
        w_next_free  = CW'(IQ_DEPTH) - pos;
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_entries    <= '0;
            r_free_count <= CW'(IQ_DEPTH);
            r_full       <= 1'b0;
        end else begin
            r_entries    <= w_next;
            r_free_count <= w_next_free;
            r_full       <= w_next_free < CW'(DISPATCH_WIDTH);
        end
    end

    assign iq_free_count = r_free_count;
    assign iq_full       = r_full;

endmodule
